beep_sequencer: RTL and testbench

BEEP_SEQUENCER -- requirements
Module: beep_sequencer

---
 rtl/beep_pkg.sv | 23 ++
 rtl/beep_sequencer_ms_tick.sv | 28 ++
 rtl/beep_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_beep_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/beep_pkg.sv
// Shared types and default timing constants for the beeper sequencer.
package beep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_KEY   = 2'd1;
  localparam logic [1:0] SRC_CHIME = 2'd2;
  localparam logic [1:0] SRC_ALARM = 2'd3;

  localparam int DEF_CLK_DIV      = 100_000;
  localparam int DEF_CLICK_MS     = 30;
  localparam int DEF_CHIME_ON_MS  = 200;
  localparam int DEF_CHIME_OFF_MS = 300;
  localparam int DEF_ALARM_ON_MS  = 500;
  localparam int DEF_ALARM_OFF_MS = 500;
  localparam int DEF_ALARM_MAX    = 60;

endpackage

// File: rtl/beep_sequencer_ms_tick.sv
// Millisecond prescaler: one-cycle tick every CLK_DIV clocks, restartable via clr.
module ms_tick #(
  parameter int CLK_DIV = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/beep_sequencer.sv
// Beeper sequencer: arbitrates key click, hourly chime and alarm into timed
// tone/gap patterns on the 512 Hz and 1 kHz beeper enables.
module beep_sequencer import beep_pkg::*; #(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int CLICK_MS     = DEF_CLICK_MS,
  parameter int CHIME_ON_MS  = DEF_CHIME_ON_MS,
  parameter int CHIME_OFF_MS = DEF_CHIME_OFF_MS,
  parameter int ALARM_ON_MS  = DEF_ALARM_ON_MS,
  parameter int ALARM_OFF_MS = DEF_ALARM_OFF_MS,
  parameter int ALARM_MAX    = DEF_ALARM_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_key,
  input  logic       req_chime,
  input  logic [4:0] chime_cnt,
  input  logic       req_alarm,
  input  logic       alarm_stop,
  output logic       open512,
  output logic       open1k,
  output logic       busy,
  output logic [1:0] grant,
  output logic       dropped
);

  localparam logic [15:0] CLICK_T     = 16'(CLICK_MS);
  localparam logic [15:0] CHIME_ON_T  = 16'(CHIME_ON_MS);
  localparam logic [15:0] CHIME_OFF_T = 16'(CHIME_OFF_MS);
  localparam logic [15:0] ALARM_ON_T  = 16'(ALARM_ON_MS);
  localparam logic [15:0] ALARM_OFF_T = 16'(ALARM_OFF_MS);
  localparam logic [15:0] ALARM_LIM   = 16'(ALARM_MAX);

  state_t      state, state_n;
  logic [1:0]  src, src_n;
  logic [15:0] ms_left, ms_n;
  logic [15:0] periods, per_n;
  logic [4:0]  rem, rem_n;
  logic        pend_v, pend_v_n;
  logic [4:0]  pend_cnt, pend_n;
  logic        drop_n, clr, tick;
  logic        go_alarm, go_chime, go_key;
  logic [4:0]  go_cnt;
  logic        chime_taken, key_taken;

  logic       alarm_go, alarm_act, chime_ok, chime_busy;
  logic [4:0] chime_left;

  assign alarm_go   = req_alarm && !alarm_stop;
  assign alarm_act  = (state != IDLE) && (src == SRC_ALARM);
  assign chime_ok   = req_chime && (chime_cnt != 5'd0);
  assign chime_busy = ((state != IDLE) && (src == SRC_CHIME)) || pend_v;
  // A chime preempted in its gap has already finished the current beep.
  assign chime_left = (state == GAP) ? rem - 5'd1 : rem;

  ms_tick #(.CLK_DIV(CLK_DIV)) u_ms_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      src      <= SRC_NONE;
      ms_left  <= '0;
      periods  <= '0;
      rem      <= '0;
      pend_v   <= 1'b0;
      pend_cnt <= '0;
      open512  <= 1'b0;
      open1k   <= 1'b0;
      busy     <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      state    <= state_n;
      src      <= src_n;
      ms_left  <= ms_n;
      periods  <= per_n;
      rem      <= rem_n;
      pend_v   <= pend_v_n;
      pend_cnt <= pend_n;
      open512  <= (state_n == TONE) && (src_n == SRC_CHIME);
      open1k   <= (state_n == TONE) && ((src_n == SRC_KEY) || (src_n == SRC_ALARM));
      busy     <= (state_n != IDLE);
      dropped  <= drop_n;
    end
  end

  assign grant = src;

  always_comb begin
    state_n     = state;
    src_n       = src;
    ms_n        = ms_left;
    per_n       = periods;
    rem_n       = rem;
    pend_v_n    = pend_v;
    pend_n      = pend_cnt;
    drop_n      = 1'b0;
    clr         = 1'b0;
    go_alarm    = 1'b0;
    go_chime    = 1'b0;
    go_key      = 1'b0;
    go_cnt      = '0;
    chime_taken = 1'b0;
    key_taken   = 1'b0;

    if (req_alarm && alarm_stop) drop_n = 1'b1;

    if (state == IDLE) begin
      if (alarm_go) begin
        go_alarm = 1'b1;
      end else if (pend_v) begin
        go_chime = 1'b1;
        go_cnt   = pend_cnt;
        pend_v_n = 1'b0;
      end else if (chime_ok) begin
        go_chime    = 1'b1;
        go_cnt      = chime_cnt;
        chime_taken = 1'b1;
      end else if (req_key) begin
        go_key    = 1'b1;
        key_taken = 1'b1;
      end
    end else if (alarm_act && alarm_stop) begin
      state_n = IDLE;
      src_n   = SRC_NONE;
    end else if (alarm_go && !alarm_act) begin
      go_alarm = 1'b1;
      if (src == SRC_KEY) begin
        drop_n = 1'b1;
      end else if (chime_left != 5'd0) begin
        pend_v_n = 1'b1;
        pend_n   = chime_left;
      end
    end else begin
      if (alarm_go) per_n = '0;
      // Phase boundary: the tick that finds one ms left ends the tone or gap.
      if (tick) begin
        if (ms_left > 16'd1) begin
          ms_n = ms_left - 16'd1;
        end else if (state == TONE) begin
          if (src == SRC_KEY) begin
            state_n = IDLE;
            src_n   = SRC_NONE;
          end else begin
            state_n = GAP;
            ms_n    = (src == SRC_CHIME) ? CHIME_OFF_T : ALARM_OFF_T;
          end
        end else if (src == SRC_CHIME) begin
          if (rem > 5'd1) begin
            rem_n   = rem - 5'd1;
            state_n = TONE;
            ms_n    = CHIME_ON_T;
          end else begin
            state_n = IDLE;
            src_n   = SRC_NONE;
          end
        end else if ((per_n + 16'd1) < ALARM_LIM) begin
          per_n   = per_n + 16'd1;
          state_n = TONE;
          ms_n    = ALARM_ON_T;
        end else begin
          state_n = IDLE;
          src_n   = SRC_NONE;
        end
      end
    end

    if (go_alarm) begin
      state_n = TONE;
      src_n   = SRC_ALARM;
      ms_n    = ALARM_ON_T;
      per_n   = '0;
      clr     = 1'b1;
    end else if (go_chime) begin
      state_n = TONE;
      src_n   = SRC_CHIME;
      ms_n    = CHIME_ON_T;
      rem_n   = go_cnt;
      clr     = 1'b1;
    end else if (go_key) begin
      state_n = TONE;
      src_n   = SRC_KEY;
      ms_n    = CLICK_T;
      clr     = 1'b1;
    end

    // Chime requests not granted now are queued one-deep or discarded.
    if (chime_ok && !chime_taken) begin
      if (chime_busy) begin
        drop_n = 1'b1;
      end else begin
        pend_v_n = 1'b1;
        pend_n   = chime_cnt;
      end
    end

    if (req_key && !key_taken) drop_n = 1'b1;
  end

endmodule

// File: tb/tb_beep_sequencer.sv
// Self-checking bench for beep_sequencer: run-length table of expected output
// waveforms driven through a scoreboard queue, plus reset-during-tone sequences.
module tb_beep_sequencer;

  localparam int I_NONE  = 0;
  localparam int I_KEY   = 1;
  localparam int I_CHIME = 2;
  localparam int I_ALARM = 4;
  localparam int I_STOP  = 8;

  // {open512, open1k, busy, grant}
  localparam logic [4:0] E_IDLE  = 5'b00000;
  localparam logic [4:0] E_KEY   = 5'b01101;
  localparam logic [4:0] E_CHON  = 5'b10110;
  localparam logic [4:0] E_CHGAP = 5'b00110;
  localparam logic [4:0] E_ALON  = 5'b01111;
  localparam logic [4:0] E_ALGAP = 5'b00111;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_key, req_chime, req_alarm, alarm_stop;
  logic [4:0] chime_cnt;
  logic       open512, open1k, busy, dropped;
  logic [1:0] grant;

  beep_sequencer #(
    .CLK_DIV(4), .CLICK_MS(3), .CHIME_ON_MS(2), .CHIME_OFF_MS(3),
    .ALARM_ON_MS(2), .ALARM_OFF_MS(2), .ALARM_MAX(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_key    (req_key),
    .req_chime  (req_chime),
    .chime_cnt  (chime_cnt),
    .req_alarm  (req_alarm),
    .alarm_stop (alarm_stop),
    .open512    (open512),
    .open1k     (open1k),
    .busy       (busy),
    .grant      (grant),
    .dropped    (dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       key, chime, alarm, stop;
    logic [4:0] cnt;
    int         len;
    logic [4:0] pat;
    logic       drop;
  } vec_t;

  vec_t       tbl[$];
  logic [5:0] exp_q[$];
  string      tag_q[$];
  int         checks = 0;
  int         errors = 0;

  function automatic vec_t seg(int in, int cnt, int len, logic [4:0] pat, int d);
    vec_t v;
    v.key   = in[0];
    v.chime = in[1];
    v.alarm = in[2];
    v.stop  = in[3];
    v.cnt   = 5'(cnt);
    v.len   = len;
    v.pat   = pat;
    v.drop  = d[0];
    return v;
  endfunction

  task automatic add_pairs(logic [4:0] on_pat, int on_len, logic [4:0] off_pat, int off_len, int n);
    for (int p = 0; p < n; p++) begin
      tbl.push_back(seg(I_NONE, 0, on_len, on_pat, 0));
      tbl.push_back(seg(I_NONE, 0, off_len, off_pat, 0));
    end
  endtask

  // Called just after a falling edge; the DUT samples at the next rising edge.
  task automatic applyStimulus(input logic k, input logic c, input logic a, input logic s,
                               input logic r, input logic [4:0] n, input logic [5:0] e,
                               input string tag);
    req_key    = k;
    req_chime  = c;
    req_alarm  = a;
    alarm_stop = s;
    rst        = r;
    chime_cnt  = n;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput();
    logic [5:0] e, got;
    string      tag;
    e   = exp_q.pop_front();
    tag = tag_q.pop_front();
    got = {open512, open1k, busy, grant, dropped};
    checks++;
    if (got !== e) begin
      errors++;
      $display("[TB] FAIL %s: got o512=%b o1k=%b busy=%b grant=%0d drop=%b, expected o512=%b o1k=%b busy=%b grant=%0d drop=%b",
               tag, got[5], got[4], got[3], got[2:1], got[0], e[5], e[4], e[3], e[2:1], e[0]);
    end
  endtask

  task automatic step(logic k, logic c, logic a, logic s, logic r, logic [4:0] n,
                      logic [4:0] pat, logic d, string tag);
    applyStimulus(k, c, a, s, r, n, {pat, d}, tag);
    checkOutput();
  endtask

  initial begin
    req_key = 0; req_chime = 0; req_alarm = 0; alarm_stop = 0; chime_cnt = '0; rst = 1'b1;

    tbl.push_back(seg(I_NONE, 0, 3, E_IDLE, 0));
    // key click, second key mid-tone is dropped
    tbl.push_back(seg(I_KEY, 0, 5, E_KEY, 0));
    tbl.push_back(seg(I_KEY, 0, 7, E_KEY, 1));
    tbl.push_back(seg(I_NONE, 0, 3, E_IDLE, 0));
    // chime: zero count ignored, three beeps, extra chime dropped
    tbl.push_back(seg(I_CHIME, 0, 3, E_IDLE, 0));
    tbl.push_back(seg(I_CHIME, 3, 8, E_CHON, 0));
    tbl.push_back(seg(I_NONE, 0, 12, E_CHGAP, 0));
    tbl.push_back(seg(I_NONE, 0, 8, E_CHON, 0));
    tbl.push_back(seg(I_CHIME, 2, 12, E_CHGAP, 1));
    add_pairs(E_CHON, 8, E_CHGAP, 12, 1);
    tbl.push_back(seg(I_NONE, 0, 3, E_IDLE, 0));
    // alarm self-stops after three periods
    tbl.push_back(seg(I_ALARM, 0, 8, E_ALON, 0));
    tbl.push_back(seg(I_NONE, 0, 8, E_ALGAP, 0));
    add_pairs(E_ALON, 8, E_ALGAP, 8, 2);
    tbl.push_back(seg(I_NONE, 0, 3, E_IDLE, 0));
    // alarm_stop in second tone
    tbl.push_back(seg(I_ALARM, 0, 8, E_ALON, 0));
    tbl.push_back(seg(I_NONE, 0, 8, E_ALGAP, 0));
    tbl.push_back(seg(I_NONE, 0, 3, E_ALON, 0));
    tbl.push_back(seg(I_STOP, 0, 3, E_IDLE, 0));
    // stop with no alarm is harmless; stop+request drops the request
    tbl.push_back(seg(I_STOP, 0, 2, E_IDLE, 0));
    tbl.push_back(seg(I_ALARM | I_STOP, 0, 3, E_IDLE, 1));
    // re-request during alarm restarts the period count
    tbl.push_back(seg(I_ALARM, 0, 8, E_ALON, 0));
    tbl.push_back(seg(I_NONE, 0, 8, E_ALGAP, 0));
    tbl.push_back(seg(I_NONE, 0, 8, E_ALON, 0));
    tbl.push_back(seg(I_NONE, 0, 3, E_ALGAP, 0));
    tbl.push_back(seg(I_ALARM, 0, 5, E_ALGAP, 0));
    add_pairs(E_ALON, 8, E_ALGAP, 8, 2);
    tbl.push_back(seg(I_NONE, 0, 3, E_IDLE, 0));
    // alarm preempts chime after beep 1; two beeps resume afterwards
    tbl.push_back(seg(I_CHIME, 3, 8, E_CHON, 0));
    tbl.push_back(seg(I_NONE, 0, 4, E_CHGAP, 0));
    tbl.push_back(seg(I_ALARM, 0, 8, E_ALON, 0));
    tbl.push_back(seg(I_NONE, 0, 8, E_ALGAP, 0));
    add_pairs(E_ALON, 8, E_ALGAP, 8, 2);
    tbl.push_back(seg(I_NONE, 0, 1, E_IDLE, 0));
    add_pairs(E_CHON, 8, E_CHGAP, 12, 2);
    tbl.push_back(seg(I_NONE, 0, 3, E_IDLE, 0));
    // key + chime + alarm together
    tbl.push_back(seg(I_KEY | I_CHIME | I_ALARM, 1, 8, E_ALON, 1));
    tbl.push_back(seg(I_NONE, 0, 8, E_ALGAP, 0));
    add_pairs(E_ALON, 8, E_ALGAP, 8, 2);
    tbl.push_back(seg(I_NONE, 0, 1, E_IDLE, 0));
    add_pairs(E_CHON, 8, E_CHGAP, 12, 1);
    tbl.push_back(seg(I_NONE, 0, 3, E_IDLE, 0));
    // alarm preempts key click, which is dropped
    tbl.push_back(seg(I_KEY, 0, 4, E_KEY, 0));
    tbl.push_back(seg(I_ALARM, 0, 3, E_ALON, 1));
    tbl.push_back(seg(I_STOP, 0, 3, E_IDLE, 0));
    // chime requested during key click waits for it
    tbl.push_back(seg(I_KEY, 0, 3, E_KEY, 0));
    tbl.push_back(seg(I_CHIME, 1, 9, E_KEY, 0));
    tbl.push_back(seg(I_NONE, 0, 1, E_IDLE, 0));
    add_pairs(E_CHON, 8, E_CHGAP, 12, 1);
    tbl.push_back(seg(I_NONE, 0, 2, E_IDLE, 0));

    @(negedge clk);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1, 5'd0, E_IDLE, 1'b0, $sformatf("reset%0d", i));

    for (int s = 0; s < tbl.size(); s++) begin
      for (int i = 0; i < tbl[s].len; i++) begin
        applyStimulus((i == 0) ? tbl[s].key : 1'b0, (i == 0) ? tbl[s].chime : 1'b0,
                      (i == 0) ? tbl[s].alarm : 1'b0, (i == 0) ? tbl[s].stop : 1'b0,
                      1'b0, (i == 0) ? tbl[s].cnt : 5'd0,
                      {tbl[s].pat, (i == 0) ? tbl[s].drop : 1'b0},
                      $sformatf("seg%0d_cyc%0d", s, i));
        checkOutput();
      end
    end

    // reset mid-alarm with a chime pending: silence and forget everything
    step(0, 0, 1, 0, 0, 5'd0, E_ALON, 1'b0, "rsta_start");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 5'd0, E_ALON, 1'b0, $sformatf("rsta_on%0d", i));
    step(0, 1, 0, 0, 0, 5'd2, E_ALON, 1'b0, "rsta_pend");
    step(0, 0, 0, 0, 0, 5'd0, E_ALON, 1'b0, "rsta_on");
    step(0, 0, 0, 0, 1, 5'd0, E_IDLE, 1'b0, "rsta_rst");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 5'd0, E_IDLE, 1'b0, $sformatf("rsta_idle%0d", i));

    // reset mid-chime tone silences open512
    step(0, 1, 0, 0, 0, 5'd2, E_CHON, 1'b0, "rstc_start");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 5'd0, E_CHON, 1'b0, $sformatf("rstc_on%0d", i));
    step(0, 0, 0, 0, 1, 5'd0, E_IDLE, 1'b0, "rstc_rst");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 5'd0, E_IDLE, 1'b0, $sformatf("rstc_idle%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
